// File: rtl/seg_enc_pkg.sv
// Shared types and constants for the 7-segment digit encoder.
// Segment byte layout is bit7..bit0 = A,B,C,D,E,F,G,DP, active high.
package seg_enc_pkg;

    typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

    localparam logic [7:0] SEG_LUT [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/seg_digit_encoder_if.sv
// Request channel into the digit encoder: value, mode and decimal points
// qualified by a valid/ready handshake.
interface seg_digit_encoder_if #(
    parameter int NUM   = 4,
    parameter int BIN_W = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] in_data;
    logic             in_hex;
    logic [NUM-1:0]   in_dp;

    modport master (output in_valid, in_data, in_hex, in_dp, input in_ready);
    modport slave  (input in_valid, in_data, in_hex, in_dp, output in_ready);
endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole register left by one taking i_bit into the LSB.
module bcd_dd_step
    import seg_enc_pkg::*;
#(
    parameter int NUM = 4
) (
    input  logic [4*NUM-1:0] i_bcd,
    input  logic             i_bit,
    output logic [4*NUM-1:0] o_bcd
);

    logic [4*NUM-1:0] w_adj;

    for (genvar g = 0; g < NUM; g++) begin : g_nib
        assign w_adj[4*g +: 4] = (i_bcd[4*g +: 4] >= 4'd5) ? i_bcd[4*g +: 4] + 4'd3
                                                           : i_bcd[4*g +: 4];
    end

    assign o_bcd = {w_adj[4*NUM-2:0], i_bit};

endmodule

// File: rtl/seg_digit_encoder.sv
// Binary-to-7-segment feeder for the scan controller; decimal via serial
// double-dabble or hex. Optional leading-zero blanking: SEG_ZERO_BLANK_EN.
module seg_digit_encoder
    import seg_enc_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int BIN_W = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_digit_encoder_if.slave   s_if,
    output logic [NUM-1:0][7:0]  led_out,
    output logic                 done,
    output logic                 ovf
);

    localparam logic [63:0] OVF_LIM   = pow10(NUM);
    localparam bit          OVF_REACH = (((64'd1 << BIN_W) - 64'd1) >= OVF_LIM);
    localparam int          CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t                r_state;
    logic [BIN_W-1:0]      r_bin;
    logic [4*NUM-1:0]      r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_hex;
    logic                  r_ovfq;
    logic [NUM-1:0]        r_dp;
    logic [NUM-1:0][7:0]   r_led;
    logic                  r_done;
    logic                  r_ovf;

    logic                  w_hs;
    logic                  w_ovf_in;
    logic [4*NUM-1:0]      w_bcd_nxt;
    logic [4*NUM-1:0]      w_hex;
    logic [4*NUM-1:0]      w_dig;
    logic [7:0]            w_base;
    logic [NUM-1:0][7:0]   w_seg;
`ifdef SEG_ZERO_BLANK_EN
    logic                  w_run;
`endif

    assign s_if.in_ready = (r_state == IDLE) & ~rst;
    assign w_hs          = s_if.in_valid & s_if.in_ready;

    // Narrow inputs can never reach 10^NUM, so the compare folds away.
    if (OVF_REACH) begin : g_ovf
        assign w_ovf_in = (64'(s_if.in_data) >= OVF_LIM);
    end else begin : g_no_ovf
        assign w_ovf_in = 1'b0;
    end

    if (BIN_W >= 4*NUM) begin : g_hex_trunc
        assign w_hex = r_bin[4*NUM-1:0];
    end else begin : g_hex_ext
        assign w_hex = {{(4*NUM-BIN_W){1'b0}}, r_bin};
    end

    bcd_dd_step #(.NUM(NUM)) u_dd (
        .i_bcd (r_bcd),
        .i_bit (r_bin[BIN_W-1]),
        .o_bcd (w_bcd_nxt)
    );

    assign w_dig = r_hex ? w_hex : r_bcd;

    // Walk from the top digit down; the zero run ends at the first nonzero.
    always_comb begin
        w_seg  = '0;
        w_base = SEG_BLANK;
`ifdef SEG_ZERO_BLANK_EN
        w_run  = 1'b1;
`endif
        for (int i = NUM-1; i >= 0; i--) begin
`ifdef SEG_ZERO_BLANK_EN
            w_run = w_run & (w_dig[4*i +: 4] == 4'd0);
`endif
            if (r_ovfq)
                w_base = SEG_DASH;
`ifdef SEG_ZERO_BLANK_EN
            else if (w_run && (i != 0))
                w_base = SEG_BLANK;
`endif
            else
                w_base = SEG_LUT[w_dig[4*i +: 4]];
            w_seg[i] = w_base | {7'd0, r_dp[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_led   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_hs) begin
                    r_bin   <= s_if.in_data;
                    r_hex   <= s_if.in_hex;
                    r_dp    <= s_if.in_dp;
                    r_ovfq  <= ~s_if.in_hex & w_ovf_in;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= (!s_if.in_hex && !w_ovf_in) ? CONV : ENC;
                end
                CONV: begin
                    r_bcd <= w_bcd_nxt;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) r_state <= ENC;
                end
                ENC: begin
                    r_led   <= w_seg;
                    r_done  <= 1'b1;
                    r_ovf   <= r_ovfq;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign led_out = r_led;
    assign done    = r_done;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_seg_digit_encoder.sv
// Directed self-checking bench for seg_digit_encoder (NUM=4, BIN_W=14).
module tb_seg_digit_encoder;

    localparam int NUM   = 4;
    localparam int BIN_W = 14;
`ifdef SEG_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'h00;
`else
    localparam logic [7:0] Z = 8'hFC;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM-1:0][7:0] led_out;
    logic done, ovf;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg_digit_encoder_if #(.NUM(NUM), .BIN_W(BIN_W)) bus ();

    seg_digit_encoder #(.NUM(NUM), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_if    (bus.slave),
        .led_out (led_out),
        .done    (done),
        .ovf     (ovf)
    );

    // Drive one request, scramble the inputs right after the handshake and
    // return the number of edges from handshake to done (-1 on timeout).
    task automatic do_req(input logic [BIN_W-1:0] d, input logic h,
                          input logic [NUM-1:0] dp, output int lat);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_hex = h; bus.in_dp = dp;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = '1; bus.in_hex = ~h; bus.in_dp = '1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_hex = 1'b0; bus.in_dp = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (led_out !== '0) $display("FAIL rst_led: got %h want 0", led_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_ready_rel: got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_decimal;
        int lat;
        logic [NUM-1:0][7:0] exp;
        do_req(14'd1234, 1'b0, 4'b0000, lat);
        exp = {8'h60, 8'hDA, 8'hF2, 8'h66};
        n_total++; if (lat !== 15) $display("FAIL dec_latency: got %0d want 15", lat); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL dec_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL dec_ovf: got %b want 0", ovf); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 1'b0) $display("FAIL dec_done_pulse: got %b want 0", done); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL dec_led_hold: got %h want %h", led_out, exp); else n_pass++;
        do_req(14'd9999, 1'b0, 4'b0000, lat);
        exp = {8'hF6, 8'hF6, 8'hF6, 8'hF6};
        n_total++; if (led_out !== exp) $display("FAIL dec9999_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL dec9999_ovf: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_hex;
        int lat;
        logic [NUM-1:0][7:0] exp;
        do_req(14'h1A5, 1'b1, 4'b0000, lat);
        exp = {Z, 8'h60, 8'hEE, 8'hB6};
        n_total++; if (lat !== 1) $display("FAIL hex_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL hex_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL hex_ovf: got %b want 0", ovf); else n_pass++;
        do_req(14'h3BCD, 1'b1, 4'b0000, lat);
        exp = {8'hF2, 8'h3E, 8'h9C, 8'h7A};
        n_total++; if (led_out !== exp) $display("FAIL hex_3bcd_led: got %h want %h", led_out, exp); else n_pass++;
    endtask

    task automatic test_overflow;
        int lat;
        logic [NUM-1:0][7:0] exp;
        do_req(14'd12000, 1'b0, 4'b0000, lat);
        exp = {8'h02, 8'h02, 8'h02, 8'h02};
        n_total++; if (lat !== 1) $display("FAIL ovf_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL ovf_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_held: got %b want 1", ovf); else n_pass++;
        do_req(14'd7, 1'b0, 4'b0000, lat);
        exp = {Z, Z, Z, 8'hE0};
        n_total++; if (lat !== 15) $display("FAIL dec7_latency: got %0d want 15", lat); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL dec7_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL dec7_ovf_clr: got %b want 0", ovf); else n_pass++;
        do_req(14'd10000, 1'b0, 4'b1001, lat);
        exp = {8'h03, 8'h02, 8'h02, 8'h03};
        n_total++; if (led_out !== exp) $display("FAIL ovf10000_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf10000_flag: got %b want 1", ovf); else n_pass++;
        do_req(14'h3FFF, 1'b1, 4'b0000, lat);
        exp = {8'hF2, 8'h8E, 8'h8E, 8'h8E};
        n_total++; if (led_out !== exp) $display("FAIL hex_big_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL hex_big_ovf: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_dp_zero;
        int lat;
        logic [NUM-1:0][7:0] exp;
        do_req(14'd1234, 1'b0, 4'b0100, lat);
        exp = {8'h60, 8'hDB, 8'hF2, 8'h66};
        n_total++; if (led_out !== exp) $display("FAIL dp_led: got %h want %h", led_out, exp); else n_pass++;
        do_req(14'd0, 1'b0, 4'b0000, lat);
        exp = {Z, Z, Z, 8'hFC};
        n_total++; if (lat !== 15) $display("FAIL zero_latency: got %0d want 15", lat); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL zero_led: got %h want %h", led_out, exp); else n_pass++;
        do_req(14'd0, 1'b1, 4'b1111, lat);
        exp = {Z | 8'h01, Z | 8'h01, Z | 8'h01, 8'hFD};
        n_total++; if (led_out !== exp) $display("FAIL zero_dp_led: got %h want %h", led_out, exp); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cnt;
        logic [NUM-1:0][7:0] prev;
        logic [NUM-1:0][7:0] exp;
        prev = led_out;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 14'd1234; bus.in_hex = 1'b0; bus.in_dp = '0;
        @(posedge clk); #1;
        bus.in_data = 14'd99;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", bus.in_ready); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (led_out !== prev) $display("FAIL busy_led_stable: got %h want %h", led_out, prev); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL busy_ready_mid: got %b want 0", bus.in_ready); else n_pass++;
        cnt = 5;
        while (!done && cnt < 40) begin @(posedge clk); #1; cnt++; end
        exp = {8'h60, 8'hDA, 8'hF2, 8'h66};
        n_total++; if (cnt !== 15) $display("FAIL busy_first_latency: got %0d want 15", cnt); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL busy_first_led: got %h want %h", led_out, exp); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL busy_ready_after_done: got %b want 1", bus.in_ready); else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL second_accept: got %b want 0", bus.in_ready); else n_pass++;
        cnt = 0;
        while (!done && cnt < 40) begin @(posedge clk); #1; cnt++; end
        exp = {Z, Z, 8'hF6, 8'hF6};
        n_total++; if (cnt !== 15) $display("FAIL second_latency: got %0d want 15", cnt); else n_pass++;
        n_total++; if (led_out !== exp) $display("FAIL second_led: got %h want %h", led_out, exp); else n_pass++;
    endtask

    task automatic test_rst_mid;
        int n_done;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 14'd1234; bus.in_hex = 1'b0; bus.in_dp = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (led_out !== '0) $display("FAIL rstmid_led: got %h want 0", led_out); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", bus.in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_ready_rel: got %b want 1", bus.in_ready); else n_pass++;
        n_done = 0;
        repeat (20) begin @(posedge clk); #1; if (done) n_done++; end
        n_total++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d want 0", n_done); else n_pass++;
        n_total++; if (led_out !== '0) $display("FAIL rstmid_led_hold: got %h want 0", led_out); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_decimal;
        test_hex;
        test_overflow;
        test_dp_zero;
        test_back_to_back;
        test_rst_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
